// File: rtl/adc_seq_pkg.sv
// Shared definitions for the ADC conversion sequencer.
//   - Default parameter values for the sequencer top.
//   - One-hot FSM state encoding.
package adc_seq_pkg;

  localparam int unsigned DefNCh        = 4;
  localparam int unsigned DefDw         = 8;
  localparam int unsigned DefSettleCyc  = 4;
  localparam int unsigned DefTimeoutCyc = 16;

  typedef enum logic [5:0] {
    StIdle    = 6'b000001,
    StSelect  = 6'b000010,
    StSettle  = 6'b000100,
    StConvert = 6'b001000,
    StStore   = 6'b010000,
    StRelease = 6'b100000
  } seq_state_e;

endpackage

// File: rtl/adc_seq_pick.sv
// Combinational lowest-set-bit finder used to choose the next channel.
// Ports:
//   mask  in   N_CH  candidate channels
//   idx   out  CH_W  index of the lowest set bit (0 when mask is empty)
//   any   out  1     mask has at least one bit set
module adc_seq_pick #(
  parameter int unsigned N_CH = 4,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] mask,
  output logic [CH_W-1:0] idx,
  output logic            any
);

  always_comb begin
    idx = '0;
    any = |mask;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (mask[i]) idx = CH_W'(i);
    end
  end

endmodule

// File: rtl/adc_conv_sequencer.sv
// Multi-channel scan controller for the SAR ADC core. Steps through the enabled
// channels lowest-first: selects the mux, waits a settling time, runs one SAR
// conversion and presents the result on a valid/ready port tagged with its channel.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   run                level: keep scanning; 0 stops after the current conversion
//   ch_mask            channels to scan, sampled at scan start
//   err_clr            pulse: clears err_sticky
//   mux_sel            analog mux channel select
//   sar_en             SAR core enable, high for the duration of one conversion
//   sar_done/sar_data  SAR core completion flag and result
//   res_valid/ready    result handshake; res_data/res_ch stable while valid
//   scan_done          1-cycle pulse when every channel of a scan is processed
//   err_sticky         a conversion timed out since the last err_clr
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned N_CH        = DefNCh,
  parameter int unsigned DW          = DefDw,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            err_clr,
  output logic [CH_W-1:0] mux_sel,
  output logic            sar_en,
  input  logic            sar_done,
  input  logic [DW-1:0]   sar_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [CH_W-1:0] res_ch,
  output logic            scan_done,
  output logic            err_sticky
);

  localparam int unsigned CntMax = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);

  seq_state_e      state_q, state_d;
  logic [N_CH-1:0] scan_mask_q, scan_mask_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   res_data_q, res_data_d;
  logic [CH_W-1:0] res_ch_q, res_ch_d;
  logic            err_q, err_d;

  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic [N_CH-1:0] mask_cleared;

  adc_seq_pick #(
    .N_CH(N_CH)
  ) u_pick (
    .mask(scan_mask_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign mask_cleared = scan_mask_q & ~(N_CH'(1) << sel_q);

  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    // Clear first so a timeout in the same cycle still sets the flag.
    err_d       = err_q & ~err_clr;
    scan_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run && (|ch_mask)) begin
          scan_mask_d = ch_mask;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        sel_d   = pick_idx;
        cnt_d   = '0;
        state_d = pick_any ? StSettle : StIdle;
      end
      StSettle: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StConvert;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StConvert: begin
        // Completion is checked before the timeout so done wins a tie.
        if (sar_done) begin
          res_data_d = sar_data;
          res_ch_d   = sel_q;
          state_d    = StStore;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStore: begin
        if (res_ready) state_d = StRelease;
      end
      StRelease: begin
        scan_mask_d = mask_cleared;
        if (mask_cleared == '0) begin
          scan_done = 1'b1;
          if (run && (|ch_mask)) begin
            scan_mask_d = ch_mask;
            state_d     = StSelect;
          end else begin
            state_d = StIdle;
          end
        end else if (run) begin
          state_d = StSelect;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      scan_mask_q <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_mask_q <= scan_mask_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      err_q       <= err_d;
    end
  end

  assign mux_sel    = sel_q;
  assign sar_en     = (state_q == StConvert);
  assign res_valid  = (state_q == StStore);
  assign res_data   = res_data_q;
  assign res_ch     = res_ch_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Self-checking bench for adc_conv_sequencer: a SAR core model answers N cycles
// after sar_en rises with data 8'h10*ch+N; a monitor records transfers, pulses and
// timing; each scenario task compares what it saw against results derived from
// the scan rules (lowest channel first, fixed per-channel cycle cost).
module tb_adc_conv_sequencer;

  localparam int unsigned N_CH        = 4;
  localparam int unsigned DW          = 8;
  localparam int unsigned SETTLE_CYC  = 4;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CH_W        = 2;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   data;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n, run, err_clr, res_ready;
  logic [N_CH-1:0] ch_mask;
  logic [CH_W-1:0] mux_sel, res_ch;
  logic            sar_en, res_valid, scan_done, err_sticky;
  logic            sar_done = 1'b0;
  logic [DW-1:0]   sar_data = '0;
  logic [DW-1:0]   res_data;

  int vectors = 0;
  int miscompares = 0;

  adc_conv_sequencer #(
    .N_CH       (N_CH),
    .DW         (DW),
    .SETTLE_CYC (SETTLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .ch_mask   (ch_mask),
    .err_clr   (err_clr),
    .mux_sel   (mux_sel),
    .sar_en    (sar_en),
    .sar_done  (sar_done),
    .sar_data  (sar_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ch    (res_ch),
    .scan_done (scan_done),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // SAR core model: done in the sar_n-th enabled cycle unless the channel is muted.
  int unsigned     sar_n = 9;
  logic [N_CH-1:0] mute = '0;
  int              en_cnt = 0;
  always @(negedge clk) begin
    if (sar_en) en_cnt = en_cnt + 1;
    else        en_cnt = 0;
    sar_done = sar_en && !mute[mux_sel] && (en_cnt == int'(sar_n));
    sar_data = sar_done ? DW'(16 * int'(mux_sel) + int'(sar_n)) : '0;
  end

  // Monitor: everything sampled on the falling edge.
  res_t            got_q[$];
  int              cyc = 0, scan_done_cnt = 0, en_rise_cnt = 0;
  int              settle_bad = 0, settle_seen = 0, hold_bad = 0;
  int              prev_done_cyc = 0, last_done_cyc = 0, sel_chg_cyc = 0, en_run = 0;
  int              en_len_last[N_CH];
  bit              sel_chg_valid = 1'b0, prev_hold = 1'b0;
  logic            prev_en = 1'b0;
  logic [CH_W-1:0] prev_sel = '0;
  res_t            prev_res;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (res_valid && res_ready) got_q.push_back({res_ch, res_data});
      if (scan_done) begin
        scan_done_cnt++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
      end
      if (mux_sel != prev_sel) begin
        sel_chg_cyc   = cyc;
        sel_chg_valid = 1'b1;
      end
      if (sar_en && !prev_en) begin
        en_rise_cnt++;
        if (sel_chg_valid) begin
          settle_seen++;
          if (cyc - sel_chg_cyc != int'(SETTLE_CYC)) settle_bad++;
          sel_chg_valid = 1'b0;
        end
      end
      if (sar_en) en_run++;
      else if (prev_en) begin
        en_len_last[prev_sel] = en_run;
        en_run = 0;
      end
      if (prev_hold && (!res_valid || ({res_ch, res_data} != prev_res))) hold_bad++;
      if (res_valid && sar_en) hold_bad++;
      prev_hold = res_valid && !res_ready;
      prev_res  = {res_ch, res_data};
    end else begin
      prev_hold     = 1'b0;
      sel_chg_valid = 1'b0;
      en_run        = 0;
    end
    prev_sel = mux_sel;
    prev_en  = sar_en;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait; kind 0: scan_done count >= arg, 1: sar_en on channel arg,
  // 2: res_valid, 3: at least arg results collected, 4: mux_sel == arg.
  task automatic wait_for(input int kind, input int arg, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       ok = scan_done_cnt >= arg;
        1:       ok = (sar_en === 1'b1) && (mux_sel == CH_W'(arg));
        2:       ok = res_valid === 1'b1;
        3:       ok = got_q.size() >= arg;
        4:       ok = mux_sel == CH_W'(arg);
        default: ok = 1'b0;
      endcase
    end
  endtask

  task automatic quiesce();
    run       = 1'b0;
    res_ready = 1'b1;
    step(60);
  endtask

  function automatic res_t exp_res(input int c, input int n);
    res_t r;
    r.ch   = CH_W'(c);
    r.data = DW'(16 * c + n);
    return r;
  endfunction

  task automatic test_reset_state();
    rst_n = 1'b0; run = 1'b0; ch_mask = '0; err_clr = 1'b0; res_ready = 1'b0;
    #3;
    vectors++;
    if ({mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky} !== '0)
      begin
      $display("FAIL reset_outputs: got %h, want 0",
               {mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky});
      miscompares++;
    end
    step(2);
    rst_n = 1'b1;
    step(3);
  endtask

  task automatic test_scan();
    logic [N_CH-1:0] m;
    int n, k, base;
    bit ok;
    int exp_ch[$];
    for (int it = 0; it < 5; it++) begin
      m = (it == 0) ? 4'b1011 : N_CH'($urandom_range(1, 15));
      n = (it == 0) ? 9 : int'($urandom_range(1, 12));
      sar_n = n; mute = '0; res_ready = 1'b1; ch_mask = m;
      got_q.delete(); exp_ch.delete();
      for (int c = 0; c < int'(N_CH); c++) if (m[c]) exp_ch.push_back(c);
      k = exp_ch.size();
      base = scan_done_cnt;
      run = 1'b1;
      wait_for(0, base + 2, 600, ok);
      vectors++;
      if (!ok) begin
        $display("FAIL scan_wait: mask %b got %0d scan_done, want %0d", m, scan_done_cnt - base, 2);
        miscompares++;
      end
      vectors++;
      if (got_q.size() != 2 * k) begin
        $display("FAIL scan_done_once: %0d results at 2nd scan_done, want %0d", got_q.size(), 2 * k);
        miscompares++;
      end
      vectors++;
      if (last_done_cyc - prev_done_cyc != k * (3 + int'(SETTLE_CYC) + n)) begin
        $display("FAIL scan_period: got %0d cycles, want %0d", last_done_cyc - prev_done_cyc,
                 k * (3 + int'(SETTLE_CYC) + n));
        miscompares++;
      end
      for (int j = 0; j < 2 * k && j < got_q.size(); j++) begin
        vectors++;
        if (got_q[j] !== exp_res(exp_ch[j % k], n)) begin
          $display("FAIL scan_result[%0d]: got %h, want %h", j, got_q[j], exp_res(exp_ch[j % k], n));
          miscompares++;
        end
      end
      quiesce();
      vectors++;
      if (en_len_last[exp_ch[0]] != n) begin
        $display("FAIL conv_len: got %0d, want %0d", en_len_last[exp_ch[0]], n);
        miscompares++;
      end
    end
    vectors++;
    if (settle_bad != 0 || settle_seen == 0) begin
      $display("FAIL settle_time: %0d bad of %0d", settle_bad, settle_seen);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    int n, e0, h0, k, base;
    bit ok;
    logic [N_CH-1:0] m;
    int exp_ch[$];
    n = int'($urandom_range(2, 10));
    sar_n = n; mute = '0; res_ready = 1'b1;
    m = 4'b0011 | N_CH'($urandom_range(0, 3) << 2);
    ch_mask = m; got_q.delete();
    run = 1'b1;
    wait_for(1, 1, 200, ok);
    res_ready = 1'b0;
    wait_for(2, 0, 100, ok);
    vectors++;
    if (!ok) begin
      $display("FAIL bp_wait_valid: res_valid %b, want 1", res_valid);
      miscompares++;
    end
    e0 = en_rise_cnt; h0 = hold_bad;
    step(20);
    vectors++;
    if ({res_valid, res_ch, res_data} !== {1'b1, exp_res(1, n)}) begin
      $display("FAIL bp_hold: got %h, want %h", {res_valid, res_ch, res_data}, {1'b1, exp_res(1, n)});
      miscompares++;
    end
    vectors++;
    if (en_rise_cnt != e0 || hold_bad != h0) begin
      $display("FAIL bp_stall: %0d new sar_en, %0d unstable cycles, want 0", en_rise_cnt - e0,
               hold_bad - h0);
      miscompares++;
    end
    res_ready = 1'b1;
    wait_for(3, 3, 200, ok);
    vectors++;
    if (!ok || got_q[1] !== exp_res(1, n) || got_q[2].ch !== (m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0))
      begin
      $display("FAIL bp_resume: got %0d results, want 3 with ch1 then next channel", got_q.size());
      miscompares++;
    end
    quiesce();

    // Random per-cycle back-pressure over two full scans.
    m = N_CH'($urandom_range(1, 15));
    ch_mask = m; got_q.delete(); exp_ch.delete();
    for (int c = 0; c < int'(N_CH); c++) if (m[c]) exp_ch.push_back(c);
    k = exp_ch.size(); base = scan_done_cnt; h0 = hold_bad;
    run = 1'b1;
    for (int i = 0; i < 1500 && scan_done_cnt < base + 2; i++) begin
      res_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    quiesce();
    vectors++;
    if (scan_done_cnt < base + 2 || got_q.size() < 2 * k || hold_bad != h0) begin
      $display("FAIL bp_random: scans %0d results %0d unstable %0d, want >=2 >=%0d 0",
               scan_done_cnt - base, got_q.size(), hold_bad - h0, 2 * k);
      miscompares++;
    end
    for (int j = 0; j < 2 * k && j < got_q.size(); j++) begin
      vectors++;
      if (got_q[j] !== exp_res(exp_ch[j % k], n)) begin
        $display("FAIL bp_random_result[%0d]: got %h, want %h", j, got_q[j],
                 exp_res(exp_ch[j % k], n));
        miscompares++;
      end
    end
  endtask

  task automatic test_timeout();
    int n, base, ch2_seen;
    bit ok;
    n = int'($urandom_range(1, 12));
    sar_n = n; mute = 4'b0100; ch_mask = 4'b0110; res_ready = 1'b1;
    got_q.delete(); base = scan_done_cnt;
    run = 1'b1;
    wait_for(0, base + 1, 300, ok);
    quiesce();
    ch2_seen = 0;
    foreach (got_q[j]) if (got_q[j].ch == 2'd2) ch2_seen++;
    vectors++;
    if (!ok || got_q.size() == 0 || got_q[0] !== exp_res(1, n) || ch2_seen != 0) begin
      $display("FAIL timeout_results: %0d results, %0d from ch2, want ch1 only", got_q.size(),
               ch2_seen);
      miscompares++;
    end
    vectors++;
    if (en_len_last[2] != int'(TIMEOUT_CYC)) begin
      $display("FAIL timeout_len: sar_en high %0d cycles, want %0d", en_len_last[2], TIMEOUT_CYC);
      miscompares++;
    end
    vectors++;
    if (err_sticky !== 1'b1) begin
      $display("FAIL timeout_err: err_sticky %b, want 1", err_sticky);
      miscompares++;
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    vectors++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL err_clr: err_sticky %b, want 0", err_sticky);
      miscompares++;
    end

    // Done in the last allowed cycle must win over the timeout.
    mute = '0; sar_n = TIMEOUT_CYC; ch_mask = 4'b0001; got_q.delete();
    run = 1'b1;
    wait_for(3, 1, 200, ok);
    quiesce();
    vectors++;
    if (!ok || got_q[0] !== exp_res(0, TIMEOUT_CYC) || err_sticky !== 1'b0) begin
      $display("FAIL done_at_timeout: ok %b err %b, want result 10 and err 0", ok, err_sticky);
      miscompares++;
    end
  endtask

  task automatic test_run_drop();
    int n, base;
    bit ok;
    n = int'($urandom_range(1, 12));
    sar_n = n; mute = '0; res_ready = 1'b1;
    ch_mask = 4'b0001 | N_CH'($urandom_range(1, 7) << 1);
    got_q.delete(); base = scan_done_cnt;
    run = 1'b1;
    wait_for(1, 0, 200, ok);
    run = 1'b0;
    step(60);
    vectors++;
    if (!ok || got_q.size() != 1 || got_q[0] !== exp_res(0, n)) begin
      $display("FAIL run_drop_result: %0d results, want exactly ch0 %h", got_q.size(),
               exp_res(0, n));
      miscompares++;
    end
    vectors++;
    if (scan_done_cnt != base || sar_en !== 1'b0 || res_valid !== 1'b0) begin
      $display("FAIL run_drop_idle: scan_done %0d sar_en %b res_valid %b, want 0 0 0",
               scan_done_cnt - base, sar_en, res_valid);
      miscompares++;
    end
    got_q.delete();
    run = 1'b1;
    wait_for(3, 1, 200, ok);
    run = 1'b0;
    step(60);
    vectors++;
    if (!ok || got_q[0].ch !== 2'd0) begin
      $display("FAIL run_restart: first channel %0d, want 0", ok ? int'(got_q[0].ch) : -1);
      miscompares++;
    end
  endtask

  task automatic test_mask_change();
    int n, base, e0;
    bit ok;
    n = int'($urandom_range(1, 12));
    sar_n = n; mute = '0; res_ready = 1'b1;
    ch_mask = 4'b0001; got_q.delete(); base = scan_done_cnt;
    run = 1'b1;
    wait_for(1, 0, 200, ok);
    ch_mask = 4'b1000;
    wait_for(0, base + 2, 300, ok);
    quiesce();
    vectors++;
    if (!ok || got_q.size() < 2 || got_q[0] !== exp_res(0, n) || got_q[1] !== exp_res(3, n))
      begin
      $display("FAIL mask_change: %0d results, want ch0 then ch3", got_q.size());
      miscompares++;
    end
    ch_mask = '0; got_q.delete();
    e0 = en_rise_cnt; base = scan_done_cnt;
    run = 1'b1;
    step(40);
    vectors++;
    if (en_rise_cnt != e0 || got_q.size() != 0 || scan_done_cnt != base || sar_en !== 1'b0) begin
      $display("FAIL mask_zero: %0d sar_en, %0d results, %0d scan_done, want none",
               en_rise_cnt - e0, got_q.size(), scan_done_cnt - base);
      miscompares++;
    end
    run = 1'b0;
    step(2);
  endtask

  task automatic test_async_reset();
    bit ok;
    sar_n = 5; mute = '0; res_ready = 1'b1; ch_mask = 4'b0100; got_q.delete();
    run = 1'b1;
    wait_for(4, 2, 100, ok);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!ok || {mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky} !== '0) begin
      $display("FAIL reset_settle: got %h, want 0",
               {mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky});
      miscompares++;
    end
    run = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(10);
    vectors++;
    if (sar_en !== 1'b0 || res_valid !== 1'b0 || got_q.size() != 0) begin
      $display("FAIL reset_idle: sar_en %b res_valid %b results %0d, want 0", sar_en, res_valid,
               got_q.size());
      miscompares++;
    end
    run = 1'b1; res_ready = 1'b0;
    wait_for(2, 0, 100, ok);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (!ok || {mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky} !== '0) begin
      $display("FAIL reset_store: got %h, want 0",
               {mux_sel, sar_en, res_valid, res_data, res_ch, scan_done, err_sticky});
      miscompares++;
    end
    run = 1'b0; res_ready = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(10);
    vectors++;
    if ({mux_sel, sar_en, res_valid, res_data, res_ch} !== '0 || got_q.size() != 0) begin
      $display("FAIL reset_store_idle: got %h results %0d, want 0",
               {mux_sel, sar_en, res_valid, res_data, res_ch}, got_q.size());
      miscompares++;
    end
  endtask

  initial begin
    test_reset_state();
    test_scan();
    test_backpressure();
    test_timeout();
    test_run_drop();
    test_mask_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
